aes_enc_scheduler: RTL and testbench
====================================

Name: aes_enc_scheduler

Overview:
- Controller that sequences the pipelined AES-128 encrypt engine and shares it between two block requesters.
- Owns the engine control strobes: key load, key-expansion warm-up, block issue and halt.
- Arbitrates the two requesters round-robin, tags every in-flight block, and routes each engine result back with its requester id.
- Sits between the host/DMA request channels and the encrypt engine.

Parameters:
- LATENCY, 12: cycles from eng_start high to the matching eng_out_valid.
- KEYGEN_CYCLES, 12: wait after the warm-up start before round keys are valid.
- MAX_INFLIGHT, 12: tag FIFO depth and the in-flight block limit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_in  in  128  new key, sampled when key_load=1.
- key_load  in  1  pulse: request a (re)key.
- abort  in  1  pulse: immediate flush.
- req0_valid / req1_valid  in  1  block request.
- req0_data / req1_data  in  128  plaintext block.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- resp_valid  out  1  ciphertext valid.
- resp_id  out  1  requester of resp_data.
- resp_data  out  128  ciphertext.
- key_ready  out  1  state is RUN.
- busy  out  1  in-flight count is nonzero, or state is neither IDLE nor RUN.
- err  out  1  sticky: eng_out_valid seen while the tag FIFO was empty.
- eng_set_key  out  1  engine key-load strobe.
- eng_key  out  128  key driven to the engine.
- eng_start  out  1  engine block strobe.
- eng_state  out  128  block driven to the engine.
- eng_halt  out  1  engine halt strobe.
- eng_out  in  128  engine ciphertext.
- eng_out_valid  in  1  engine result valid.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous, active-low.
- Reset values:
  - All outputs 0, state IDLE.
  - Tag FIFO empty, inflight=0, last_grant=1 (req0 wins first), key register 0.
- key_load in any state latches key_in into the key register. A later key_load overwrites it.
- State machine:
  - IDLE: on key_load -> KEY_LOAD.
  - KEY_LOAD: eng_halt=1 for one cycle, then eng_set_key=1 with eng_key=key register for one cycle, then -> WARMUP.
  - WARMUP:
    - First cycle: eng_start=1 with eng_state=0. Push a tag with discard=1; inflight+1.
    - Then wait KEYGEN_CYCLES cycles, then -> RUN.
  - RUN:
    - Accept blocks (see Issue).
    - On key_load -> DRAIN.
  - DRAIN: no new requests accepted. When inflight==0 -> KEY_LOAD.
  - abort (any state): eng_halt=1 for one cycle; tag FIFO flushed; inflight=0; state -> IDLE; resp_valid forced 0 from the next cycle on. abort has priority over key_load in the same cycle; the key is still latched.
- Arbitration and issue (RUN only):
  - eligible = inflight < MAX_INFLIGHT.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid -> grant = ~last_grant.
  - reqN_ready = eligible AND grant==N, combinational. Ready is never asserted to both requesters.
  - Handshake in cycle T:
    - last_grant <= N.
    - Cycle T+1: eng_start=1 and eng_state=reqN_data (both registered).
    - Tag {id=N, discard=0} pushed at T+1; inflight+1.
  - Maximum issue rate: one block per cycle.
- Completion:
  - On eng_out_valid: pop the tag FIFO; inflight-1.
  - If discard=0: next cycle resp_valid=1, resp_id=tag id, resp_data=eng_out.
  - If discard=1: no response.
  - If the FIFO is empty: set err, no pop, inflight unchanged.
- Response path: not stallable; the consumer must accept a response every cycle it is valid. Results return in issue order.
- Push and pop in the same cycle: inflight unchanged; FIFO pointers wrap modulo MAX_INFLIGHT.
- inflight == MAX_INFLIGHT: both readies low until a pop.
- End-to-end latency: request handshake to resp_valid = LATENCY+2 cycles.
- Reset mid-operation: everything returns to reset values immediately. Engine results still arriving after reset are discarded and raise err.

Test Plan:
- Reset, key_load with key 000102…0f; hold a bench engine model → eng_halt, then eng_set_key with eng_key=000102…0f, one warm-up eng_start with block 0; key_ready rises 12 cycles later; the warm-up result produces no resp_valid.
- In RUN, req0 sends 00112233445566778899aabbccddeeff once → resp_valid exactly LATENCY+2 cycles after the handshake, resp_id=0, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Both requesters valid continuously for 8 cycles → grants alternate 0,1,0,1…; responses return in the same id order with correct data.
- Engine model stalled (no eng_out_valid) with 13 back-to-back requests → exactly 12 accepted; both readies low until the first eng_out_valid, then one more accept.
- key_load mid-stream with 5 blocks in flight → no new accepts; all 5 responses delivered; then eng_halt/eng_set_key with the new key and warm-up; key_ready reasserts.
- abort with 4 blocks in flight → eng_halt pulse; no resp_valid for the in-flight blocks; busy=0; state IDLE. A spurious eng_out_valid afterwards sets err=1.

Source files
------------

// File: rtl/aes_enc_scheduler.sv
// aes_enc_scheduler: controls a pipelined AES-128 encrypt engine. It owns the
// key-load / warm-up / issue / halt strobes, shares the engine between two block
// requesters round-robin and returns each ciphertext tagged with its requester.
module aes_enc_scheduler #(
    parameter int unsigned LATENCY       = 12,
    parameter int unsigned KEYGEN_CYCLES = 12,
    parameter int unsigned MAX_INFLIGHT  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         abort,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [127:0] resp_data,
    output logic         key_ready,
    output logic         busy,
    output logic         err,
    output logic         eng_set_key,
    output logic [127:0] eng_key,
    output logic         eng_start,
    output logic [127:0] eng_state,
    output logic         eng_halt,
    input  logic [127:0] eng_out,
    input  logic         eng_out_valid
);

    localparam int unsigned PTR_W  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned WARM_W = (KEYGEN_CYCLES > 1) ? $clog2(KEYGEN_CYCLES) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [CNT_W:0]    MAX_OCC   = (CNT_W + 1)'(MAX_INFLIGHT);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(KEYGEN_CYCLES - 1);

    // One block per cycle needs a tag slot for every engine pipeline stage.
    if (MAX_INFLIGHT < LATENCY) begin : gen_depth_check
        $error("aes_enc_scheduler: MAX_INFLIGHT must be at least LATENCY");
    end

    typedef enum logic [2:0] {
        StIdle,
        StKeyHalt,
        StKeySet,
        StWarmup,
        StRun,
        StDrain
    } state_e;

    // discard marks the warm-up block, whose result is never returned.
    typedef struct packed {
        logic id;
        logic discard;
    } tag_t;

    state_e              state_q, state_d;
    logic [127:0]        key_q;
    logic [WARM_W-1:0]   warm_cnt_q;
    logic                last_grant_q;
    logic                halt_q;

    logic                start_q;
    logic [127:0]        start_data_q;
    tag_t                start_tag_q;

    tag_t                tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    inflight_q;

    logic                resp_valid_q;
    logic                resp_id_q;
    logic [127:0]        resp_data_q;
    logic                err_q;

    logic                fifo_empty;
    logic                pop;
    tag_t                head_tag;
    logic [CNT_W:0]      occupancy;
    logic                eligible;
    logic                grant;
    logic                issue_ok;
    logic                accept;

    // Occupancy counts the block registered for issue but not yet pushed; a pop
    // this cycle frees a slot in time for a new handshake.
    always_comb begin
        fifo_empty = (inflight_q == '0);
        pop        = eng_out_valid && !fifo_empty;
        head_tag   = tag_mem[rd_ptr_q];
        occupancy  = {1'b0, inflight_q} + {{CNT_W{1'b0}}, start_q};
        eligible   = (occupancy < MAX_OCC) || pop;
    end

    // Round-robin grant: contention goes to the requester not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end
        issue_ok   = (state_q == StRun) && eligible && !abort;
        req0_ready = issue_ok && req0_valid && !grant;
        req1_ready = issue_ok && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (key_load) state_d = StKeyHalt;
            StKeyHalt: state_d = StKeySet;
            StKeySet:  state_d = StWarmup;
            StWarmup:  if (warm_cnt_q == WARM_LAST) state_d = StRun;
            StRun:     if (key_load) state_d = StDrain;
            StDrain:   if (fifo_empty && !start_q) state_d = StKeyHalt;
            default:   state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // State register, key register, warm-up timer and arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            key_q        <= '0;
            warm_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            halt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= abort;
            if (key_load) begin
                key_q <= key_in;
            end
            if (state_q == StWarmup) begin
                warm_cnt_q <= warm_cnt_q + 1'b1;
            end else begin
                warm_cnt_q <= '0;
            end
            if (accept) begin
                last_grant_q <= grant;
            end
        end
    end

    // Issue register: the warm-up block or the granted request, one cycle after
    // the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            start_data_q <= '0;
            start_tag_q  <= '0;
        end else begin
            start_q <= 1'b0;
            if (abort) begin
                start_q <= 1'b0;
            end else if (state_q == StKeySet) begin
                start_q      <= 1'b1;
                start_data_q <= '0;
                start_tag_q  <= '{id: 1'b0, discard: 1'b1};
            end else if (accept) begin
                start_q      <= 1'b1;
                start_data_q <= grant ? req1_data : req0_data;
                start_tag_q  <= '{id: grant, discard: 1'b0};
            end
        end
    end

    // Tag storage; entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (start_q) begin
            tag_mem[wr_ptr_q] <= start_tag_q;
        end
    end

    // Tag FIFO pointers and in-flight count; the tag is pushed as the block issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
        end else if (abort) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            if (start_q) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({start_q, pop})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Response register and sticky error for results with no matching tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            if (eng_out_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
            if (abort) begin
                resp_valid_q <= 1'b0;
            end else begin
                resp_valid_q <= pop && !head_tag.discard;
                if (pop) begin
                    resp_id_q   <= head_tag.id;
                    resp_data_q <= eng_out;
                end
            end
        end
    end

    // Output decode.
    always_comb begin
        resp_valid  = resp_valid_q;
        resp_id     = resp_id_q;
        resp_data   = resp_data_q;
        key_ready   = (state_q == StRun);
        busy        = !fifo_empty || ((state_q != StIdle) && (state_q != StRun));
        err         = err_q;
        eng_set_key = (state_q == StKeySet);
        eng_key     = key_q;
        eng_start   = start_q;
        eng_state   = start_data_q;
        eng_halt    = halt_q || (state_q == StKeyHalt);
    end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// tb_aes_enc_scheduler: directed bench with a behavioural engine model, a
// table of arbitration vectors and hand-written multi-cycle sequences.
module tb_aes_enc_scheduler;

    localparam int LAT = 12;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load, abort;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_data, req1_data;
    logic         resp_valid, resp_id, key_ready, busy, err;
    logic [127:0] resp_data;
    logic         eng_set_key, eng_start, eng_halt;
    logic [127:0] eng_key, eng_state;
    logic [127:0] eng_out = '0;
    logic         eng_out_valid = 1'b0;

    int nchk = 0;
    int nfail = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    aes_enc_scheduler dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .abort(abort),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .key_ready(key_ready), .busy(busy), .err(err),
        .eng_set_key(eng_set_key), .eng_key(eng_key), .eng_start(eng_start),
        .eng_state(eng_state), .eng_halt(eng_halt), .eng_out(eng_out),
        .eng_out_valid(eng_out_valid)
    );

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Stand-in cipher: the FIPS-197 vector for K0/P0, otherwise a keyed mix.
    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        return {p[95:0], p[127:96]} ^ k ^ {4{32'ha5a5_5a5a}};
    endfunction

    function automatic logic [127:0] dat(input int g, input int k);
        return {32'(g), 32'(k), 32'hc0de_0000 + 32'(k), 32'(g * 7 + k)};
    endfunction

    // Engine model: fixed latency, optional output stall, halt flushes the pipe.
    logic         stall = 1'b0;
    logic         honor_halt = 1'b1;
    logic [127:0] mdl_key = '0;
    logic [127:0] pend_data[$];
    int           pend_due[$];

    always @(posedge clk) begin
        ecount = ecount + 1;
        eng_out_valid <= 1'b0;
        if (eng_halt && honor_halt) begin
            pend_data.delete();
            pend_due.delete();
        end
        if (eng_set_key) mdl_key = eng_key;
        if (eng_start) begin
            pend_data.push_back(enc(mdl_key, eng_state));
            pend_due.push_back(ecount + LAT - 1);
        end
        if (!stall && pend_due.size() > 0 && pend_due[0] <= ecount) begin
            eng_out_valid <= 1'b1;
            eng_out <= pend_data.pop_front();
            void'(pend_due.pop_front());
        end
    end

    // Response scoreboard; cyc < 0 means arrival time is not checked.
    typedef struct {
        logic         id;
        logic [127:0] data;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    task automatic expect_resp(input logic id, input logic [127:0] data, input int cyc);
        exp_t e;
        e.id = id;
        e.data = data;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check(resp_valid == 1'b0, "unexpected_resp", 128'(resp_valid), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(resp_id == e.id, "resp_id", 128'(resp_id), 128'(e.id));
                check(resp_data == e.data, "resp_data", resp_data, e.data);
                if (e.cyc >= 0) check(ecount == e.cyc, "resp_latency", 128'(ecount), 128'(e.cyc));
            end
        end
    end

    task automatic wait_sb_empty(input int bound);
        for (int n = 0; n < bound && sb.size() != 0; n++) @(negedge clk);
        #2;
        check(sb.size() == 0, "drain_responses", 128'(sb.size()), 128'(0));
    endtask

    typedef struct {
        logic r0, r1;
        logic [127:0] d0, d1;
        logic e0, e1;
    } vec_t;
    vec_t vt[14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int s, acc, both_hi, bad_grant, viol, hit;
        bit found, halt_seen, exp_g;

        // Arbitration vectors; last grant is req0 when the table starts.
        vt[0] = '{1'b0, 1'b1, dat(0, 0), dat(1, 0), 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{1'b1, 1'b1, dat(0, i), dat(1, i), (i % 2) == 1, (i % 2) == 0};
        vt[9]  = '{1'b1, 1'b0, dat(0, 9), dat(1, 9), 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b0, dat(0, 10), dat(1, 10), 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, dat(0, 11), dat(1, 11), 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, dat(0, 12), dat(1, 12), 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b1, dat(0, 13), dat(1, 13), 1'b1, 1'b0};

        rst_n = 1'b0; key_in = '0; key_load = 1'b0; abort = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        repeat (3) @(negedge clk);
        check({req0_ready, req1_ready, resp_valid, resp_id, key_ready, busy, err, eng_set_key,
               eng_start, eng_halt, |eng_key, |eng_state, |resp_data} == 13'd0,
              "reset_outputs", 128'(busy), 128'(0));
        rst_n = 1'b1;

        // Key load, halt, set-key, warm-up.
        @(negedge clk); key_in = K0; key_load = 1'b1;
        @(negedge clk); key_load = 1'b0;
        found = 0;
        for (int n = 0; n < 6; n++) begin
            if (eng_halt) begin found = 1; break; end
            @(negedge clk);
        end
        check(found, "key_halt", 128'(found), 128'(1));
        @(negedge clk);
        check(eng_set_key && !eng_halt && eng_key == K0, "set_key", eng_key, K0);
        @(negedge clk);
        check(eng_start && !eng_set_key && eng_state == '0, "warmup_start", eng_state, '0);
        check(busy && !key_ready, "busy_warmup", 128'(busy), 128'(1));
        s = ecount;
        for (int n = 0; n < 30 && !key_ready; n++) @(negedge clk);
        check(ecount - s == 12, "key_ready_delay", 128'(ecount - s), 128'(12));
        repeat (3) @(negedge clk);
        check(!busy && !err, "warmup_retired", 128'({busy, err}), 128'(0));

        // Single FIPS-197 block from req0.
        @(negedge clk); req0_valid = 1'b1; req0_data = P0;
        #1;
        check(req0_ready && !req1_ready, "single_ready", 128'({req0_ready, req1_ready}), 128'(2));
        expect_resp(1'b0, C0, ecount + LAT + 2);
        @(negedge clk); req0_valid = 1'b0;
        wait_sb_empty(30);

        // Arbitration table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req0_valid = vt[i].r0; req1_valid = vt[i].r1;
            req0_data = vt[i].d0; req1_data = vt[i].d1;
            #1;
            check({req0_ready, req1_ready} == {vt[i].e0, vt[i].e1}, $sformatf("arb_vec%0d", i),
                  128'({req0_ready, req1_ready}), 128'({vt[i].e0, vt[i].e1}));
            if (vt[i].e0) expect_resp(1'b0, enc(K0, vt[i].d0), ecount + LAT + 2);
            if (vt[i].e1) expect_resp(1'b1, enc(K0, vt[i].d1), ecount + LAT + 2);
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        wait_sb_empty(40);

        // Stalled engine: in-flight limit, then one accept on the first result.
        stall = 1'b1;
        acc = 0; both_hi = 0; bad_grant = 0; exp_g = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = dat(2, acc); req1_data = dat(3, acc);
            #1;
            if (req0_ready && req1_ready) both_hi++;
            if (req0_ready || req1_ready) begin
                if (req1_ready != exp_g) bad_grant++;
                expect_resp(exp_g, enc(K0, exp_g ? dat(3, acc) : dat(2, acc)), -1);
                exp_g = ~exp_g;
                acc++;
            end
        end
        check(acc == 12, "stall_accepts", 128'(acc), 128'(12));
        @(negedge clk); stall = 1'b0;
        #1;
        check(!req0_ready && !req1_ready, "full_readies_low", 128'({req0_ready, req1_ready}), 128'(0));
        hit = 0;
        for (int n = 0; n < 4 && acc < 13; n++) begin
            @(negedge clk); #1;
            if (req0_ready || req1_ready) begin
                if (eng_out_valid) hit = 1;
                if (req0_ready && req1_ready) both_hi++;
                if (req1_ready != exp_g) bad_grant++;
                expect_resp(exp_g, enc(K0, exp_g ? dat(3, acc) : dat(2, acc)), -1);
                exp_g = ~exp_g;
                acc++;
            end
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        check(acc == 13, "release_accept", 128'(acc), 128'(13));
        check(hit == 1, "accept_on_pop", 128'(hit), 128'(1));
        check(both_hi == 0 && bad_grant == 0, "stall_grants", 128'({both_hi, bad_grant}), 128'(0));
        wait_sb_empty(60);

        // Re-key with five blocks in flight.
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req0_valid = 1'b1; req0_data = dat(4, i);
            #1;
            if (!req0_ready) viol++;
            expect_resp(1'b0, enc(K0, dat(4, i)), ecount + LAT + 2);
        end
        check(viol == 0, "prekey_accepts", 128'(viol), 128'(0));
        @(negedge clk); req0_valid = 1'b0; key_in = K1; key_load = 1'b1;
        @(negedge clk); key_load = 1'b0; req0_valid = 1'b1; req0_data = dat(5, 0);
        viol = 0; halt_seen = 0; found = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (req0_ready || req1_ready) viol++;
            if (eng_halt) halt_seen = 1;
            if (eng_set_key) begin found = 1; break; end
            @(negedge clk);
        end
        check(found && halt_seen, "rekey_strobes", 128'({found, halt_seen}), 128'(3));
        check(viol == 0, "drain_no_accept", 128'(viol), 128'(0));
        check(sb.size() == 0, "drain_delivered", 128'(sb.size()), 128'(0));
        check(eng_key == K1, "rekey_value", eng_key, K1);
        @(negedge clk); req0_valid = 1'b0;
        for (int n = 0; n < 30 && !key_ready; n++) @(negedge clk);
        check(key_ready, "key_ready_again", 128'(key_ready), 128'(1));
        @(negedge clk); req1_valid = 1'b1; req1_data = dat(5, 1);
        #1;
        check(req1_ready, "newkey_ready", 128'(req1_ready), 128'(1));
        expect_resp(1'b1, enc(K1, dat(5, 1)), ecount + LAT + 2);
        @(negedge clk); req1_valid = 1'b0;
        wait_sb_empty(30);

        // Abort with four blocks in flight; the engine keeps returning them.
        honor_halt = 1'b0;
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); req1_valid = 1'b1; req1_data = dat(6, i);
            #1;
            if (!req1_ready) viol++;
        end
        check(viol == 0, "preabort_accepts", 128'(viol), 128'(0));
        @(negedge clk); req1_valid = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check(eng_halt, "abort_halt", 128'(eng_halt), 128'(1));
        check(!busy && !key_ready, "abort_idle", 128'({busy, key_ready}), 128'(0));
        check(!err, "err_before_late", 128'(err), 128'(0));
        @(negedge clk);
        check(!eng_halt, "abort_halt_pulse", 128'(eng_halt), 128'(0));
        repeat (20) @(negedge clk);
        check(err, "err_on_orphan", 128'(err), 128'(1));
        check(!busy && !key_ready, "stays_idle", 128'({busy, key_ready}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
